// File: rtl/dmem_pkg.sv
// Shared types for the multi-cycle MIPS data memory (dmem_ctrl).
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NUM_LANES = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_ctrl: store byte enables and data replication,
// load lane extraction with sign/zero extension. Purely combinational.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]           i_off,
  input  logic [1:0]           i_size,
  input  logic                 i_sign_ext,
  input  logic [DATA_W-1:0]    i_wr_data,
  input  logic [DATA_W-1:0]    i_rd_word,
  output logic [NUM_LANES-1:0] o_be,
  output logic [DATA_W-1:0]    o_wr_lanes,
  output logic [DATA_W-1:0]    o_ld_data
);

  logic [DATA_W-1:0] w_shift;

  assign w_shift = i_rd_word >> {i_off, 3'b000};

  // Store data is replicated to every lane so the byte enables alone pick the target.
  always_comb begin
    o_be       = '0;
    o_wr_lanes = i_wr_data;
    o_ld_data  = '0;
    unique case (size_e'(i_size))
      SZ_BYTE: begin
        o_be       = NUM_LANES'(1) << i_off;
        o_wr_lanes = {NUM_LANES{i_wr_data[7:0]}};
        o_ld_data  = {{(DATA_W-8){i_sign_ext & w_shift[7]}}, w_shift[7:0]};
      end
      SZ_HALF: begin
        o_be       = i_off[1] ? 4'b1100 : 4'b0011;
        o_wr_lanes = {2{i_wr_data[15:0]}};
        o_ld_data  = {{(DATA_W-16){i_sign_ext & w_shift[15]}}, w_shift[15:0]};
      end
      SZ_WORD: begin
        o_be       = '1;
        o_ld_data  = i_rd_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Multi-cycle data memory for the MIPS MEM stage with LATENCY wait states.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned half/word accesses as errors.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ready,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  size_e               r_size;
  logic                r_sext;
  logic                r_write;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

  logic                w_req, w_accept, w_access, w_we;
  logic                w_range_err, w_size_err, w_align_err, w_err;
  logic [1:0]          w_off;
  logic [IDX_W-1:0]    w_idx;
  logic [NUM_LANES-1:0] w_be;
  logic [DATA_W-1:0]   w_wr_lanes, w_ld_data;

  assign w_req       = MemRead | MemWrite;
  assign w_idx       = r_addr[IDX_W+1:2];
  assign w_range_err = |r_addr[ADDR_W-1:IDX_W+2];
  assign w_size_err  = (r_size == SZ_RSVD);

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_off       = r_addr[1:0];
  assign w_align_err = ((r_size == SZ_HALF) && r_addr[0]) ||
                       ((r_size == SZ_WORD) && (r_addr[1:0] != 2'b00));
`else
  // Without the check, low address bits below the access size are dropped.
  assign w_off       = (r_size == SZ_WORD) ? 2'b00 :
                       (r_size == SZ_HALF) ? {r_addr[1], 1'b0} : r_addr[1:0];
  assign w_align_err = 1'b0;
`endif

  assign w_err = w_range_err | w_size_err | w_align_err;
  assign w_we  = w_access & r_write & ~w_err;

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .i_off      (w_off),
    .i_size     (r_size),
    .i_sign_ext (r_sext),
    .i_wr_data  (r_wdata),
    .i_rd_word  (r_mem[w_idx]),
    .o_be       (w_be),
    .o_wr_lanes (w_wr_lanes),
    .o_ld_data  (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    busy        = 1'b0;
    ready       = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_req) begin
        w_accept    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_cnt == '0) begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        ready       = 1'b1;
        w_accept    = w_req;
        w_state_nxt = w_req ? S_WAIT : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rd_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt   <= CNT_W'(LATENCY - 1);
        r_addr  <= addr_in;
        r_wdata <= wr_data;
        r_size  <= size_e'(size);
        r_sext  <= sign_ext;
        r_write <= MemWrite;
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_access) begin
        r_rd_data <= (w_err | r_write) ? '0 : w_ld_data;
        r_err     <= w_err;
      end
    end
  end

  // Array is never cleared; reset only blocks a store landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && w_we)
      for (int b = 0; b < NUM_LANES; b++)
        if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wr_lanes[b*8 +: 8];
  end

  assign rd_data = r_rd_data;
  assign err     = r_err;

endmodule
